// File: rtl/cdb_pkg.sv
// Shared types and widths for the CDB writeback slice.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W    = 32;
  localparam int unsigned CDB_TAG_W     = 6;
  localparam int unsigned CDB_BUF_DEPTH = 2;
  localparam int unsigned NUM_SRC       = 4;
  localparam int unsigned SRC_W         = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_DIV = 2'd0,
    SRC_MUL = 2'd1,
    SRC_INT = 2'd2,
    SRC_LS  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer; a push into a full FIFO survives only with a same-cycle pop.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = CDB_BUF_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  cdb_entry_t       wr_entry,
  output cdb_entry_t       rd_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign drop     = push && !push_ok;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// Collects execution-unit results and broadcasts one per cycle on the CDB with round-robin arbitration.
module cdb_writeback
  import cdb_pkg::*;
#(
  parameter int unsigned DATA_W    = CDB_DATA_W,
  parameter int unsigned TAG_W     = CDB_TAG_W,
  parameter int unsigned BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              res_vld_div,
  input  logic              res_vld_mul,
  input  logic              res_vld_int,
  input  logic              res_vld_ls,
  input  logic [TAG_W-1:0]  res_tag_div,
  input  logic [TAG_W-1:0]  res_tag_mul,
  input  logic [TAG_W-1:0]  res_tag_int,
  input  logic [TAG_W-1:0]  res_tag_ls,
  input  logic [DATA_W-1:0] res_data_div,
  input  logic [DATA_W-1:0] res_data_mul,
  input  logic [DATA_W-1:0] res_data_int,
  input  logic [DATA_W-1:0] res_data_ls,
  output logic              cdb_vld,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        cdb_src,
  output logic [3:0]        buf_afull,
  output logic              ovf_err,
  output logic [3:0]        ovf_src
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [NUM_SRC-1:0] vld;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] drop;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] afull_nxt;
  cdb_entry_t         in_e   [NUM_SRC];
  cdb_entry_t         head_e [NUM_SRC];
  logic [CNT_W-1:0]   cnt     [NUM_SRC];
  logic [CNT_W-1:0]   cnt_nxt [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   gnt_src;
  logic               gnt_vld;
  cdb_entry_t         gnt_e;

  assign vld = {res_vld_ls, res_vld_int, res_vld_mul, res_vld_div};
  assign in_e[SRC_DIV] = '{tag: CDB_TAG_W'(res_tag_div), data: CDB_DATA_W'(res_data_div)};
  assign in_e[SRC_MUL] = '{tag: CDB_TAG_W'(res_tag_mul), data: CDB_DATA_W'(res_data_mul)};
  assign in_e[SRC_INT] = '{tag: CDB_TAG_W'(res_tag_int), data: CDB_DATA_W'(res_data_int)};
  assign in_e[SRC_LS]  = '{tag: CDB_TAG_W'(res_tag_ls),  data: CDB_DATA_W'(res_data_ls)};

  // Rotating-priority scan starting at rr_ptr; a source competes with its head or its bypass.
  always_comb begin
    logic [SRC_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_src = '0;
    idx     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr + SRC_W'(k);
      if (!gnt_vld && (!empty[idx] || vld[idx])) begin
        gnt_vld = 1'b1;
        gnt_src = idx;
      end
    end
  end

  assign gnt_e = empty[gnt_src] ? in_e[gnt_src] : head_e[gnt_src];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign gnt[i]       = gnt_vld && (gnt_src == SRC_W'(i));
    assign pop[i]       = gnt[i] && !empty[i];
    assign push[i]      = vld[i] && !(gnt[i] && empty[i]);
    assign cnt_nxt[i]   = cnt[i] + CNT_W'(push[i] && (!full[i] || pop[i])) - CNT_W'(pop[i]);
    assign afull_nxt[i] = (cnt_nxt[i] >= CNT_W'(BUF_DEPTH - 1));

    cdb_src_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_b    (rst_b),
      .push     (push[i]),
      .pop      (pop[i]),
      .wr_entry (in_e[i]),
      .rd_entry (head_e[i]),
      .count    (cnt[i]),
      .empty    (empty[i]),
      .full     (full[i]),
      .drop     (drop[i])
    );
  end

  // Broadcast payload holds when nothing is granted; drop flags are sticky until reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr    <= '0;
      cdb_vld   <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      buf_afull <= '0;
      ovf_err   <= 1'b0;
      ovf_src   <= '0;
    end else begin
      cdb_vld   <= gnt_vld;
      buf_afull <= afull_nxt;
      ovf_src   <= ovf_src | drop;
      ovf_err   <= ovf_err | (|drop);
      if (gnt_vld) begin
        rr_ptr   <= gnt_src + SRC_W'(1);
        cdb_tag  <= TAG_W'(gnt_e.tag);
        cdb_data <= DATA_W'(gnt_e.data);
        cdb_src  <= gnt_src;
      end
    end
  end

endmodule
